mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Controller between the 32-bit word-addressable memory (one read port, one write port, 10-bit word address) and its three users: instruction fetch (read requester 0), load unit (read requester 1) and store unit (write requester). It arbitrates the single read port between the two readers with valid/ready handshakes. It tracks in-flight reads so each response returns to its owner, and it gates the write port with an explicit write enable. It also resolves same-address read/write collisions so a read never returns stale data.

## Interface
- AW, 10, word-address width
- DW, 32, data width
- RD_LAT, 1, memory read latency in cycles (1..4), addr_r sampled at edge k, mem_data_out valid after edge k+RD_LAT-1
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_valid / r1_valid  in  1  read request
- r0_addr / r1_addr  in  AW  read word address
- r0_ready / r1_ready  out  1  read request accepted this cycle when valid&&ready
- r0_rvalid / r1_rvalid  out  1  one-cycle read response strobe
- r0_rdata / r1_rdata  out  DW  response data, valid only with rvalid
- w_valid  in  1  write request
- w_addr  in  AW; w_data  in  DW
- w_ready  out  1  write accepted this cycle
- mem_addr_r  out  AW; mem_addr_w  out  AW; mem_data_in  out  DW; mem_we  out  1  to memory
- mem_data_out  in  DW  from memory

## Operation
- Reset (async, rst_n=0): r*_ready=0, w_ready=0, mem_we=0, r*_rvalid=0, response pipeline cleared, last-grant pointer = 1 (so r0 wins first tie). Address/data outputs = 0.
- Write path: w_ready=1 whenever out of reset. mem_we = w_valid; mem_addr_w = w_addr; mem_data_in = w_data (combinational). Writes never stall.
- Read arbitration (combinational each cycle): candidate = arbiter choice among valid readers; mem_addr_r = candidate address (0 if none).
- Collision: if w_valid and candidate address == w_addr, both r*_ready = 0 that cycle; the read retries next cycle and observes the new data.
- Otherwise rN_ready = 1 only for the chosen requester; the other's ready = 0.
- Response pipeline: RD_LAT-deep shift register of {valid, owner}. On accepted read at edge k, stage 0 loads {1, owner}. rOwner_rvalid = last stage valid; r0_rdata = r1_rdata = mem_data_out.
- Back-to-back reads allowed every cycle; up to RD_LAT reads in flight. Responses return strictly in issue order.
- Mid-operation reset: in-flight responses dropped, no rvalid after rst_n deasserts until new requests.

## Timing
- Read handshake at edge k → rvalid high for exactly the cycle following edge k+RD_LAT-1 (RD_LAT=1: cycle right after acceptance).
- Write handshake at edge k → memory updated at edge k; read accepted at edge k+1 to same address returns new data.
- Ready depends combinationally on valid/address inputs; no combinational path from rdata to any ready.
- Pointer update: last-grant pointer := owner at each accepted read; unchanged on idle or collision cycles.

## Configuration
- MEM_PORT_ARB_RR_EN defined: round-robin; on tie, grant requester ≠ last-grant pointer. Neither requester waits more than one accepted read of the other.
- Not defined: fixed priority, r0 (fetch) always wins a tie; pointer register is not implemented; r1 may starve.

## Test plan
- Reset: hold rst_n=0 with all valids high → all ready/rvalid/mem_we = 0; release → writes to addr 0,1,2 (0xAAAABBBB, 0x12345678, 0xDEADBEEF) accepted, mem_we high exactly 3 cycles.
- Single reader: r0 reads addr 1,2,0 back to back → r0_rvalid on 3 consecutive cycles, data 0x12345678, 0xDEADBEEF, 0xAAAABBBB; r1_rvalid stays 0.
- Contention, RR_EN defined: r0 and r1 valid for 4 cycles (addr 0 and 1) → grants alternate r0,r1,r0,r1; each gets 2 responses with correct data. Without macro: r0 granted all 4 cycles, r1_ready=0.
- Collision: same cycle w_valid addr 1 data 0xFFFF0000 and r1_valid addr 1 → r1_ready=0 that cycle, accepted next cycle, r1_rdata = 0xFFFF0000. Read of addr 2 with write to addr 1 → no stall.
- RD_LAT=3: 3 back-to-back reads alternating owners → rvalids start 3 cycles after first acceptance, in order, correct owners.
- Reset mid-flight: RD_LAT=3, assert rst_n low with 2 reads pending → no rvalid ever produced for them after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory read port between fetch and load, passes store writes through.
// MEM_PORT_ARB_RR_EN selects round-robin arbitration; otherwise fetch (r0) has fixed priority.
module mem_port_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_valid,
    input  logic [AW-1:0] r0_addr,
    output logic          r0_ready,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_valid,
    input  logic [AW-1:0] r1_addr,
    output logic          r1_ready,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    input  logic          w_valid,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic          w_ready,
    output logic [AW-1:0] mem_addr_r,
    output logic [AW-1:0] mem_addr_w,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_we,
    input  logic [DW-1:0] mem_data_out
);

    logic              grant_any;
    logic              grant_sel;
    logic [AW-1:0]     cand_addr;
    logic              collide;
    logic              accept;
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_owner;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_sel;
        end
    end
`endif

    // grant_sel: 0 selects r0, 1 selects r1
    always_comb begin
        grant_any = r0_valid | r1_valid;
`ifdef MEM_PORT_ARB_RR_EN
        grant_sel = (r0_valid && r1_valid) ? ~last_grant : ~r0_valid;
`else
        grant_sel = ~r0_valid;
`endif
        cand_addr = '0;
        if (grant_any) begin
            cand_addr = grant_sel ? r1_addr : r0_addr;
        end
        // a read racing a write to the same word waits one cycle so it sees the new data
        collide = w_valid && grant_any && (cand_addr == w_addr);
        accept  = rst_n && grant_any && !collide;
    end

    always_comb begin
        r0_ready    = accept && !grant_sel;
        r1_ready    = accept && grant_sel;
        w_ready     = rst_n;
        mem_we      = rst_n && w_valid;
        mem_addr_w  = rst_n ? w_addr : '0;
        mem_data_in = rst_n ? w_data : '0;
        mem_addr_r  = rst_n ? cand_addr : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_owner <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_owner[0] <= grant_sel;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    always_comb begin
        r0_rvalid = pipe_valid[RD_LAT-1] && !pipe_owner[RD_LAT-1];
        r1_rvalid = pipe_valid[RD_LAT-1] && pipe_owner[RD_LAT-1];
        r0_rdata  = mem_data_out;
        r1_rdata  = mem_data_out;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench driving RD_LAT=1 and RD_LAT=3 instances with shared stimulus.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_valid, r1_valid, w_valid;
    logic [AW-1:0] r0_addr, r1_addr, w_addr;
    logic [DW-1:0] w_data;

    logic          r0_ready_a, r1_ready_a, r0_rvalid_a, r1_rvalid_a, w_ready_a, mem_we_a;
    logic [DW-1:0] r0_rdata_a, r1_rdata_a, mem_data_in_a, mem_data_out_a;
    logic [AW-1:0] mem_addr_r_a, mem_addr_w_a;
    logic          r0_ready_b, r1_ready_b, r0_rvalid_b, r1_rvalid_b, w_ready_b, mem_we_b;
    logic [DW-1:0] r0_rdata_b, r1_rdata_b, mem_data_in_b, mem_data_out_b;
    logic [AW-1:0] mem_addr_r_b, mem_addr_w_b;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready_a),
        .r0_rvalid(r0_rvalid_a), .r0_rdata(r0_rdata_a),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready_a),
        .r1_rvalid(r1_rvalid_a), .r1_rdata(r1_rdata_a),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready_a),
        .mem_addr_r(mem_addr_r_a), .mem_addr_w(mem_addr_w_a), .mem_data_in(mem_data_in_a),
        .mem_we(mem_we_a), .mem_data_out(mem_data_out_a)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready_b),
        .r0_rvalid(r0_rvalid_b), .r0_rdata(r0_rdata_b),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready_b),
        .r1_rvalid(r1_rvalid_b), .r1_rdata(r1_rdata_b),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready_b),
        .mem_addr_r(mem_addr_r_b), .mem_addr_w(mem_addr_w_b), .mem_data_in(mem_data_in_b),
        .mem_we(mem_we_b), .mem_data_out(mem_data_out_b)
    );

    // memory models: latency 1 (one output register) and latency 3 (three registers)
    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];
    logic [DW-1:0] rd_a, rd_b0, rd_b1, rd_b2;

    always_ff @(posedge clk) begin
        if (mem_we_a) mem_a[mem_addr_w_a] <= mem_data_in_a;
        rd_a <= mem_a[mem_addr_r_a];
        if (mem_we_b) mem_b[mem_addr_w_b] <= mem_data_in_b;
        rd_b0 <= mem_b[mem_addr_r_b];
        rd_b1 <= rd_b0;
        rd_b2 <= rd_b1;
    end
    assign mem_data_out_a = rd_a;
    assign mem_data_out_b = rd_b2;

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          q_a[$];
    rsp_t          q_b[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
`ifdef MEM_PORT_ARB_RR_EN
    logic          ptr = 1'b1;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic          any, pick1, col, ex0, ex1;
        logic [AW-1:0] ca;
        rsp_t          e;
        #1;
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
`ifdef MEM_PORT_ARB_RR_EN
            ptr = 1'b1;
`endif
        end
        any = r0_valid || r1_valid;
        if (r0_valid && r1_valid) begin
`ifdef MEM_PORT_ARB_RR_EN
            pick1 = (ptr == 1'b0);
`else
            pick1 = 1'b0;
`endif
        end else begin
            pick1 = r1_valid;
        end
        ca  = !any ? '0 : (pick1 ? r1_addr : r0_addr);
        col = w_valid && any && (ca == w_addr);
        ex0 = rst_n && any && !col && !pick1;
        ex1 = rst_n && any && !col && pick1;
        check("l1 r0_ready", r0_ready_a, ex0);
        check("l1 r1_ready", r1_ready_a, ex1);
        check("l3 r0_ready", r0_ready_b, ex0);
        check("l3 r1_ready", r1_ready_b, ex1);
        check("w_ready", w_ready_a, rst_n);
        check("l1 mem_we", mem_we_a, rst_n && w_valid);
        check("l3 mem_we", mem_we_b, rst_n && w_valid);
        check("mem_addr_r", mem_addr_r_a, rst_n ? ca : '0);
        check("mem_addr_w", mem_addr_w_a, rst_n ? w_addr : '0);
        check("mem_data_in", mem_data_in_a, rst_n ? w_data : '0);
        if (ex0 || ex1) begin
            e.owner = ex1;
            e.data  = shadow[ca];
            e.due   = cyc + 1;
            q_a.push_back(e);
            e.due   = cyc + 3;
            q_b.push_back(e);
`ifdef MEM_PORT_ARB_RR_EN
            ptr = ex1;
`endif
        end
        if (rst_n && w_valid) shadow[w_addr] = w_data;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        ex0 = q_a.size() > 0 && q_a[0].due == cyc && !q_a[0].owner;
        ex1 = q_a.size() > 0 && q_a[0].due == cyc && q_a[0].owner;
        check("l1 r0_rvalid", r0_rvalid_a, ex0);
        check("l1 r1_rvalid", r1_rvalid_a, ex1);
        if (ex0 || ex1) begin
            e = q_a.pop_front();
            check("l1 rdata", e.owner ? r1_rdata_a : r0_rdata_a, e.data);
        end
        ex0 = q_b.size() > 0 && q_b[0].due == cyc && !q_b[0].owner;
        ex1 = q_b.size() > 0 && q_b[0].due == cyc && q_b[0].owner;
        check("l3 r0_rvalid", r0_rvalid_b, ex0);
        check("l3 r1_rvalid", r1_rvalid_b, ex1);
        if (ex0 || ex1) begin
            e = q_b.pop_front();
            check("l3 rdata", e.owner ? r1_rdata_b : r0_rdata_b, e.data);
        end
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic v1,
                         input logic [AW-1:0] a1, input logic wv, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd);
        r0_valid = v0; r0_addr = a0;
        r1_valid = v1; r1_addr = a1;
        w_valid  = wv; w_addr  = wa; w_data = wd;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        // reset with every requester active
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 2, 1, 3, 32'h1);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 32'hAAAABBBB);
        drive(0, 0, 0, 0, 1, 1, 32'h12345678);
        drive(0, 0, 0, 0, 1, 2, 32'hDEADBEEF);
        idle(1);
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(4);
        // contention for four cycles
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 1, 0, 0, 0);
        idle(4);
        // same-address collision, then different-address write without stall
        drive(0, 0, 1, 1, 1, 1, 32'hFFFF0000);
        drive(0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 1, 2, 1, 1, 32'h00000055);
        idle(4);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 2, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(5);
        // reset with reads still in flight
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(6);
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom);
        end
        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
